multicycle_ctrl_fsm: RTL and testbench
======================================

Name: multicycle_ctrl_fsm

Overview:
- Control unit of the multicycle RV64 datapath. Sequences fetch, decode, execute, memory and writeback for each instruction.
- Inputs: opcode, full instruction word, ALU zero flag.
- Outputs: every register write-enable, mux select and ALU operation the datapath consumes.
- Sole source of control for PC, IR, A/B, AluOut, MDR, register bank and data memory.

Parameters:
INSTR_RD_LAT, 1, cycles from PC valid to instruction-memory data valid; range 1..7.
DATA_RD_LAT, 1, cycles from AluOut valid to data-memory data valid; range 1..7.

Ports:
CLK  in  1  clock, rising edge
RST  in  1  synchronous active-high reset
op_code  in  7  IR[6:0]
INSTRUCAO  in  32  IR[31:0]; funct3 = [14:12], funct7 bit = [30]
ZERO_ALU  in  1  ALU result == 0, combinational
WRITE_PC  out  1  PC register load
LOAD_IR  out  1  instruction register load
WR_MEM_INSTR  out  1  instruction memory write; constant 0
write_reg_A, write_reg_B  out  1 each  A/B register loads
WR_ALU_OUT  out  1  AluOut load
wrDataMemReg  out  1  memory data register load
wrDataMem  out  1  data memory write
WR_BANCO_REG  out  1  register bank write
SELECT_MUX_DATA  out  1  writeback source: 0 = AluOut, 1 = MDR
SELETOR_MUX_A  out  2  0 = PC, 1 = A
SELETOR_MUX_B  out  2  0 = B, 1 = const 4, 2 = sign-ext, 3 = sign-ext<<1
operacao  out  3  ALU op: 001 add, 010 sub, 011 and
SELETOR_ALU  out  1  PC source: 0 = ALU, 1 = AluOut
reset_wire  out  1  high while in RESET state
estado  out  4  current state encoding, for debug

Behaviour:
- Moore machine. All outputs decode from the registered state; BRANCH additionally uses ZERO_ALU for WRITE_PC.
- Every write-enable defaults to 0. Selects and operacao default to 0 unless a state sets them.
- RST=1 at a clock edge forces state RESET from any state, mid-instruction included. Outputs are 0 except reset_wire=1.
- State encodings: RESET=0, FETCH=1, FETCH_WAIT=2, DECODE=3, EXEC_R=4, EXEC_I=5, ADDR=6, MEM_RD=7, MEM_LATCH=8, WB_LOAD=9, MEM_WR=10, WB_ALU=11, BRANCH=12, PC_INC=13, HALT=14.
- RESET -> FETCH.
- FETCH: no writes.
  - INSTR_RD_LAT=1: -> FETCH_WAIT.
  - Otherwise: 3-bit wait counter, loaded 0 on entry; stay until counter == INSTR_RD_LAT-1, then -> FETCH_WAIT.
- FETCH_WAIT: LOAD_IR=1 -> DECODE.
- DECODE: write_reg_A=1, write_reg_B=1, WR_ALU_OUT=1, mux A=0, mux B=3, add. AluOut <= PC + (imm<<1), the branch target.
- Dispatch from DECODE by opcode:
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 0000011 or 0100011 -> ADDR
  - 1100011 -> BRANCH
  - anything else, including 1110011 -> HALT
- EXEC_R: mux A=1, mux B=0, WR_ALU_OUT=1; ALU op from funct3/funct7:
  - funct3=000, bit30=0 -> add
  - funct3=000, bit30=1 -> sub
  - funct3=111 -> and
  - any other combination -> HALT, with no AluOut write.
  - Valid ops -> WB_ALU.
- EXEC_I: addi only (funct3=000, else HALT). mux A=1, mux B=2, add, WR_ALU_OUT=1 -> WB_ALU.
- ADDR: mux A=1, mux B=2, add, WR_ALU_OUT=1.
  - ld: funct3=011 -> MEM_RD.
  - sd: funct3=011 -> MEM_WR.
  - Other funct3 -> HALT.
- MEM_RD: wait DATA_RD_LAT cycles using the same counter scheme as FETCH -> MEM_LATCH.
- MEM_LATCH: wrDataMemReg=1 -> WB_LOAD.
- WB_LOAD: WR_BANCO_REG=1, SELECT_MUX_DATA=1, PC increment -> FETCH.
- MEM_WR: wrDataMem=1, PC increment -> FETCH.
- WB_ALU: WR_BANCO_REG=1, SELECT_MUX_DATA=0, PC increment -> FETCH.
- PC increment means mux A=0, mux B=1, add, SELETOR_ALU=0, WRITE_PC=1 in the same cycle.
- BRANCH: mux A=1, mux B=0, sub.
  - Taken: beq (funct3=000) with ZERO_ALU=1, or bne (001) with ZERO_ALU=0. WRITE_PC=1, SELETOR_ALU=1 -> FETCH.
  - Not taken -> PC_INC.
  - Other funct3 -> HALT.
- PC_INC: PC increment -> FETCH.
- HALT: absorbing, all writes 0. Only RST exits.
- Cycle counts at LAT=1: R/I-type 5, ld 7, sd 5, branch taken 4, branch not taken 5.
- Writes to register x0 are filtered by the register bank, not here.
- No output ever asserts two of WRITE_PC / WR_ALU_OUT / wrDataMem driven from conflicting ALU uses in one cycle.

Test Plan:
- Reset then hold RST=0, IR = add x3,x1,x2 (0x002081B3) -> estado 0,1,2,3,4,11,1. In state 11: WR_BANCO_REG=1, WRITE_PC=1, SELETOR_MUX_B=1.
- IR = sub (0x402081B3) -> EXEC_R has operacao=010. IR = and (0x0020F1B3) -> operacao=011.
- IR = ld x5,8(x1) (0x0080B283), DATA_RD_LAT=3 -> MEM_RD held 3 cycles. wrDataMemReg pulses once. WB_LOAD has SELECT_MUX_DATA=1. 9 cycles total.
- IR = sd (0x0050B423) -> wrDataMem=1 for exactly one cycle, in the same cycle as WRITE_PC=1.
- beq with ZERO_ALU=1 -> BRANCH: WRITE_PC=1, SELETOR_ALU=1, next FETCH. With ZERO_ALU=0 -> PC_INC, then WRITE_PC with SELETOR_ALU=0.
- IR = 0x00100073 (ebreak) -> HALT persists 20 cycles with all enables 0. RST asserted mid-EXEC_R -> next estado=0, reset_wire=1.

Source files
------------

// File: rtl/multicycle_ctrl_fsm_if.sv
// Control bus between the multicycle RV64 controller and its datapath.
// The controller holds the master modport. It reads the instruction fields and
// the ALU zero flag. It drives every load enable, mux select and ALU operation.
interface multicycle_ctrl_fsm_if;
  logic [6:0]  op_code;
  logic [31:0] INSTRUCAO;
  logic        ZERO_ALU;

  logic        WRITE_PC;
  logic        LOAD_IR;
  logic        WR_MEM_INSTR;
  logic        write_reg_A;
  logic        write_reg_B;
  logic        WR_ALU_OUT;
  logic        wrDataMemReg;
  logic        wrDataMem;
  logic        WR_BANCO_REG;
  logic        SELECT_MUX_DATA;
  logic [1:0]  SELETOR_MUX_A;
  logic [1:0]  SELETOR_MUX_B;
  logic [2:0]  operacao;
  logic        SELETOR_ALU;
  logic        reset_wire;
  logic [3:0]  estado;

  modport master (
    input  op_code, INSTRUCAO, ZERO_ALU,
    output WRITE_PC, LOAD_IR, WR_MEM_INSTR, write_reg_A, write_reg_B,
           WR_ALU_OUT, wrDataMemReg, wrDataMem, WR_BANCO_REG, SELECT_MUX_DATA,
           SELETOR_MUX_A, SELETOR_MUX_B, operacao, SELETOR_ALU, reset_wire, estado
  );

  modport slave (
    output op_code, INSTRUCAO, ZERO_ALU,
    input  WRITE_PC, LOAD_IR, WR_MEM_INSTR, write_reg_A, write_reg_B,
           WR_ALU_OUT, wrDataMemReg, wrDataMem, WR_BANCO_REG, SELECT_MUX_DATA,
           SELETOR_MUX_A, SELETOR_MUX_B, operacao, SELETOR_ALU, reset_wire, estado
  );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Moore control unit for the multicycle RV64 datapath.
// It sequences fetch, decode, execute, memory and writeback for each instruction.
// Supported instructions: add/sub/and, addi, ld, sd, beq and bne. Any other
// encoding parks the machine in HALT until RST.
// The outputs are registered next to the state. The one exception is the
// BRANCH redirect, which must follow the live ZERO_ALU flag.
// INSTR_RD_LAT and DATA_RD_LAT must each lie in the range 1..7.
module multicycle_ctrl_fsm #(
  parameter int INSTR_RD_LAT = 1,
  parameter int DATA_RD_LAT  = 1
) (
  input logic                   CLK,
  input logic                   RST,
  multicycle_ctrl_fsm_if.master bus
);

  typedef enum logic [3:0] {
    ST_RESET      = 4'd0,
    ST_FETCH      = 4'd1,
    ST_FETCH_WAIT = 4'd2,
    ST_DECODE     = 4'd3,
    ST_EXEC_R     = 4'd4,
    ST_EXEC_I     = 4'd5,
    ST_ADDR       = 4'd6,
    ST_MEM_RD     = 4'd7,
    ST_MEM_LATCH  = 4'd8,
    ST_WB_LOAD    = 4'd9,
    ST_MEM_WR     = 4'd10,
    ST_WB_ALU     = 4'd11,
    ST_BRANCH     = 4'd12,
    ST_PC_INC     = 4'd13,
    ST_HALT       = 4'd14
  } state_t;

  typedef enum logic [2:0] {
    ALU_NONE = 3'b000,
    ALU_ADD  = 3'b001,
    ALU_SUB  = 3'b010,
    ALU_AND  = 3'b011
  } alu_op_t;

  typedef struct packed {
    logic       write_pc;
    logic       load_ir;
    logic       write_reg_a;
    logic       write_reg_b;
    logic       wr_alu_out;
    logic       wr_mdr;
    logic       wr_mem;
    logic       wr_bank;
    logic       sel_data;
    logic [1:0] sel_a;
    logic [1:0] sel_b;
    alu_op_t    op;
    logic       sel_alu;
    logic       reset_wire;
  } ctrl_t;

  localparam logic [6:0] OP_R_TYPE = 7'b0110011;
  localparam logic [6:0] OP_I_TYPE = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] INSTR_LAST = 3'(INSTR_RD_LAT - 1);
  localparam logic [2:0] DATA_LAST  = 3'(DATA_RD_LAT - 1);

  state_t     state, state_nxt;
  logic [2:0] wait_cnt;
  ctrl_t      ctrl_q;
  logic [2:0] funct3;
  logic       funct7_b30;
  logic       branch_taken;
  logic       unused_instr_bits;

  assign funct3            = bus.INSTRUCAO[14:12];
  assign funct7_b30        = bus.INSTRUCAO[30];
  assign unused_instr_bits = ^{bus.INSTRUCAO[31], bus.INSTRUCAO[29:15], bus.INSTRUCAO[11:0]};

  // Returns the control word for state s. Invalid function fields suppress the AluOut write.
  function automatic ctrl_t decode_outputs(input state_t s, input logic [2:0] f3, input logic b30);
    ctrl_t c;
    c = '0;
    case (s)
      ST_RESET:      c.reset_wire = 1'b1;
      ST_FETCH_WAIT: c.load_ir = 1'b1;
      ST_DECODE: begin
        // Latch A/B and precompute the branch target PC + (imm << 1).
        c.write_reg_a = 1'b1;
        c.write_reg_b = 1'b1;
        c.wr_alu_out  = 1'b1;
        c.sel_b       = 2'd3;
        c.op          = ALU_ADD;
      end
      ST_EXEC_R: begin
        c.sel_a = 2'd1;
        if (f3 == 3'b000)      c.op = b30 ? ALU_SUB : ALU_ADD;
        else if (f3 == 3'b111) c.op = ALU_AND;
        c.wr_alu_out = (c.op != ALU_NONE);
      end
      ST_EXEC_I, ST_ADDR: begin
        c.sel_a      = 2'd1;
        c.sel_b      = 2'd2;
        c.op         = ALU_ADD;
        c.wr_alu_out = (s == ST_EXEC_I) ? (f3 == 3'b000) : (f3 == 3'b011);
      end
      ST_MEM_LATCH:  c.wr_mdr = 1'b1;
      ST_BRANCH: begin
        c.sel_a = 2'd1;
        c.op    = ALU_SUB;
      end
      default: ;
    endcase
    if (s == ST_WB_LOAD || s == ST_MEM_WR || s == ST_WB_ALU || s == ST_PC_INC) begin
      // PC <= PC + 4 through the ALU.
      c.sel_a    = 2'd0;
      c.sel_b    = 2'd1;
      c.op       = ALU_ADD;
      c.sel_alu  = 1'b0;
      c.write_pc = 1'b1;
    end
    c.wr_bank  = (s == ST_WB_LOAD) || (s == ST_WB_ALU);
    c.sel_data = (s == ST_WB_LOAD);
    c.wr_mem   = (s == ST_MEM_WR);
    return c;
  endfunction

  // The branch outcome depends on the live compare, so it stays combinational.
  assign branch_taken = (state == ST_BRANCH) &&
                        (((funct3 == 3'b000) && bus.ZERO_ALU) ||
                         ((funct3 == 3'b001) && !bus.ZERO_ALU));

  // Next-state selection from the current state, the instruction fields and the wait counter.
  always_comb begin
    // NOTE: default first so that every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    case (state)
      ST_RESET:      state_nxt = ST_FETCH;
      ST_FETCH:      if (wait_cnt == INSTR_LAST) state_nxt = ST_FETCH_WAIT;
      ST_FETCH_WAIT: state_nxt = ST_DECODE;
      ST_DECODE: begin
        case (bus.op_code)
          OP_R_TYPE:         state_nxt = ST_EXEC_R;
          OP_I_TYPE:         state_nxt = ST_EXEC_I;
          OP_LOAD, OP_STORE: state_nxt = ST_ADDR;
          OP_BRANCH:         state_nxt = ST_BRANCH;
          default:           state_nxt = ST_HALT;
        endcase
      end
      ST_EXEC_R:
        state_nxt = ((funct3 == 3'b000) || (funct3 == 3'b111)) ? ST_WB_ALU : ST_HALT;
      ST_EXEC_I:     state_nxt = (funct3 == 3'b000) ? ST_WB_ALU : ST_HALT;
      ST_ADDR: begin
        if (funct3 != 3'b011)             state_nxt = ST_HALT;
        else if (bus.op_code == OP_STORE) state_nxt = ST_MEM_WR;
        else                              state_nxt = ST_MEM_RD;
      end
      ST_MEM_RD:     if (wait_cnt == DATA_LAST) state_nxt = ST_MEM_LATCH;
      ST_MEM_LATCH:  state_nxt = ST_WB_LOAD;
      ST_WB_LOAD, ST_MEM_WR, ST_WB_ALU, ST_PC_INC:
                     state_nxt = ST_FETCH;
      ST_BRANCH: begin
        if (branch_taken)                              state_nxt = ST_FETCH;
        else if ((funct3 == 3'b000) || (funct3 == 3'b001)) state_nxt = ST_PC_INC;
        else                                           state_nxt = ST_HALT;
      end
      ST_HALT:       state_nxt = ST_HALT;
      default:       state_nxt = ST_HALT;
    endcase
  end

  // State, wait counter and registered control word, all with a synchronous reset.
  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignments, so every register here samples values from before the edge.
    if (RST) begin
      state    <= ST_RESET;
      wait_cnt <= 3'd0;
      ctrl_q   <= decode_outputs(ST_RESET, funct3, funct7_b30);
    end else begin
      state    <= state_nxt;
      // The counter restarts on each state entry. It is only compared in FETCH and MEM_RD.
      wait_cnt <= (state_nxt == state) ? wait_cnt + 3'd1 : 3'd0;
      ctrl_q   <= decode_outputs(state_nxt, funct3, funct7_b30);
    end
  end

  assign bus.WRITE_PC        = ctrl_q.write_pc | branch_taken;
  assign bus.SELETOR_ALU     = ctrl_q.sel_alu | branch_taken;
  assign bus.LOAD_IR         = ctrl_q.load_ir;
  assign bus.WR_MEM_INSTR    = 1'b0;
  assign bus.write_reg_A     = ctrl_q.write_reg_a;
  assign bus.write_reg_B     = ctrl_q.write_reg_b;
  assign bus.WR_ALU_OUT      = ctrl_q.wr_alu_out;
  assign bus.wrDataMemReg    = ctrl_q.wr_mdr;
  assign bus.wrDataMem       = ctrl_q.wr_mem;
  assign bus.WR_BANCO_REG    = ctrl_q.wr_bank;
  assign bus.SELECT_MUX_DATA = ctrl_q.sel_data;
  assign bus.SELETOR_MUX_A   = ctrl_q.sel_a;
  assign bus.SELETOR_MUX_B   = ctrl_q.sel_b;
  assign bus.operacao        = ctrl_q.op;
  assign bus.reset_wire      = ctrl_q.reset_wire;
  assign bus.estado          = state;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Scoreboard bench for multicycle_ctrl_fsm.
// A per-instruction reference model queues the expected control word of every cycle.
// A negedge monitor pops one entry per cycle and compares it with the DUT outputs.
module tb_multicycle_ctrl_fsm;
  localparam int INSTR_LAT = 1;
  localparam int DATA_LAT  = 3;
  localparam int N_RANDOM  = 150;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  multicycle_ctrl_fsm_if bus();

  multicycle_ctrl_fsm #(.INSTR_RD_LAT(INSTR_LAT), .DATA_RD_LAT(DATA_LAT)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  typedef struct packed {
    logic [3:0] estado;
    logic       write_pc;
    logic       load_ir;
    logic       wr_mem_instr;
    logic       write_reg_a;
    logic       write_reg_b;
    logic       wr_alu_out;
    logic       wr_mdr;
    logic       wr_mem;
    logic       wr_bank;
    logic       sel_data;
    logic [1:0] sel_a;
    logic [1:0] sel_b;
    logic [2:0] op;
    logic       sel_alu;
    logic       reset_wire;
  } obs_t;

  obs_t  exp_q[$];
  int    checks = 0;
  int    errors = 0;
  string cur_tag = "reset";
  int    budget;
  int    pushed;
  bit    truncated;
  bit    done = 1'b0;
  bit    drain_checked = 1'b0;

  function automatic obs_t blank(input logic [3:0] st);
    obs_t o = '0;
    o.estado = st;
    return o;
  endfunction

  function automatic obs_t reset_obs();
    obs_t o = blank(4'd0);
    o.reset_wire = 1'b1;
    return o;
  endfunction

  // Next sequential instruction: PC <= PC + 4.
  function automatic obs_t pc_step(input obs_t base);
    obs_t o = base;
    o.sel_a    = 2'd0;
    o.sel_b    = 2'd1;
    o.op       = 3'b001;
    o.sel_alu  = 1'b0;
    o.write_pc = 1'b1;
    return o;
  endfunction

  // Queues one expected cycle. Stops queueing when the truncation budget runs out.
  task automatic emit(input obs_t o);
    if (budget > 0) begin
      exp_q.push_back(o);
      budget--;
      pushed++;
    end else begin
      truncated = 1'b1;
    end
  endtask

  // Reference model: the cycle-by-cycle control trace of a single instruction.
  task automatic model_instr(input logic [31:0] ir, input logic z, input int halt_hold,
                             output bit halted);
    logic [6:0] opc;
    logic [2:0] f3;
    obs_t       o;
    bit         ok;
    opc    = ir[6:0];
    f3     = ir[14:12];
    halted = 1'b0;
    for (int i = 0; i < INSTR_LAT; i++) emit(blank(4'd1));
    o = blank(4'd2); o.load_ir = 1'b1; emit(o);
    o = blank(4'd3);
    o.write_reg_a = 1'b1; o.write_reg_b = 1'b1; o.wr_alu_out = 1'b1;
    o.sel_b = 2'd3; o.op = 3'b001;
    emit(o);
    case (opc)
      7'b0110011: begin
        o = blank(4'd4); o.sel_a = 2'd1;
        if (f3 == 3'd0)      o.op = ir[30] ? 3'b010 : 3'b001;
        else if (f3 == 3'd7) o.op = 3'b011;
        ok = (o.op != 3'b000);
        o.wr_alu_out = ok;
        emit(o);
        if (ok) begin
          o = pc_step(blank(4'd11)); o.wr_bank = 1'b1; emit(o);
        end else halted = 1'b1;
      end
      7'b0010011: begin
        ok = (f3 == 3'd0);
        o = blank(4'd5); o.sel_a = 2'd1; o.sel_b = 2'd2; o.op = 3'b001; o.wr_alu_out = ok;
        emit(o);
        if (ok) begin
          o = pc_step(blank(4'd11)); o.wr_bank = 1'b1; emit(o);
        end else halted = 1'b1;
      end
      7'b0000011, 7'b0100011: begin
        ok = (f3 == 3'd3);
        o = blank(4'd6); o.sel_a = 2'd1; o.sel_b = 2'd2; o.op = 3'b001; o.wr_alu_out = ok;
        emit(o);
        if (!ok) halted = 1'b1;
        else if (opc == 7'b0000011) begin
          for (int i = 0; i < DATA_LAT; i++) emit(blank(4'd7));
          o = blank(4'd8); o.wr_mdr = 1'b1; emit(o);
          o = pc_step(blank(4'd9)); o.wr_bank = 1'b1; o.sel_data = 1'b1; emit(o);
        end else begin
          o = pc_step(blank(4'd10)); o.wr_mem = 1'b1; emit(o);
        end
      end
      7'b1100011: begin
        o = blank(4'd12); o.sel_a = 2'd1; o.op = 3'b010;
        if (f3 == 3'd0 || f3 == 3'd1) begin
          if ((f3 == 3'd0) ? z : !z) begin
            o.write_pc = 1'b1; o.sel_alu = 1'b1; emit(o);
          end else begin
            emit(o);
            emit(pc_step(blank(4'd13)));
          end
        end else begin
          emit(o);
          halted = 1'b1;
        end
      end
      default: halted = 1'b1;
    endcase
    if (halted) for (int i = 0; i < halt_hold; i++) emit(blank(4'd14));
  endtask

  // Entered one cycle after a posedge while the DUT is in FETCH. On return the DUT is in FETCH again.
  task automatic run_instr(input string tag, input logic [31:0] ir, input logic z,
                           input int halt_hold, input int trunc);
    bit halted;
    cur_tag       = tag;
    bus.INSTRUCAO = ir;
    bus.op_code   = ir[6:0];
    bus.ZERO_ALU  = z;
    budget        = trunc;
    pushed        = 0;
    truncated     = 1'b0;
    model_instr(ir, z, halt_hold, halted);
    repeat (pushed - 1) begin @(posedge CLK); #1; end
    if (halted || truncated) begin
      RST = 1'b1;
      @(posedge CLK); #1;
      cur_tag = {tag, "/reset"};
      exp_q.push_back(reset_obs());
      RST = 1'b0;
      @(posedge CLK); #1;
    end else begin
      @(posedge CLK); #1;
    end
  endtask

  obs_t got, want;

  // Monitor: compares each cycle the model predicted, then checks the queue has drained.
  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      got.estado       = bus.estado;
      got.write_pc     = bus.WRITE_PC;
      got.load_ir      = bus.LOAD_IR;
      got.wr_mem_instr = bus.WR_MEM_INSTR;
      got.write_reg_a  = bus.write_reg_A;
      got.write_reg_b  = bus.write_reg_B;
      got.wr_alu_out   = bus.WR_ALU_OUT;
      got.wr_mdr       = bus.wrDataMemReg;
      got.wr_mem       = bus.wrDataMem;
      got.wr_bank      = bus.WR_BANCO_REG;
      got.sel_data     = bus.SELECT_MUX_DATA;
      got.sel_a        = bus.SELETOR_MUX_A;
      got.sel_b        = bus.SELETOR_MUX_B;
      got.op           = bus.operacao;
      got.sel_alu      = bus.SELETOR_ALU;
      got.reset_wire   = bus.reset_wire;
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL %s state%0d: got estado=%0d ctrl=%h, expected estado=%0d ctrl=%h",
                 cur_tag, want.estado, got.estado, got[22:0], want.estado, want[22:0]);
      end
    end else if (done && !drain_checked) begin
      drain_checked = 1'b1;
      checks++;
      if (bus.estado !== 4'd1) begin
        errors++;
        $display("FAIL end_state: got estado=%0d, expected 1", bus.estado);
      end
    end
  end

  initial begin
    logic [31:0] ir;
    int          cls;
    int          hold;
    int          trunc;
    RST           = 1'b1;
    bus.INSTRUCAO = 32'h0000_0013;
    bus.op_code   = 7'h13;
    bus.ZERO_ALU  = 1'b0;
    @(posedge CLK); #1; exp_q.push_back(reset_obs());
    @(posedge CLK); #1; exp_q.push_back(reset_obs()); RST = 1'b0;
    @(posedge CLK); #1;

    run_instr("add",         32'h002081B3, 1'b0, 1, 1000);
    run_instr("sub",         32'h402081B3, 1'b1, 1, 1000);
    run_instr("and",         32'h0020F1B3, 1'b0, 1, 1000);
    run_instr("addi",        32'h00508093, 1'b0, 1, 1000);
    run_instr("ld",          32'h0080B283, 1'b0, 1, 1000);
    run_instr("sd",          32'h0050B423, 1'b1, 1, 1000);
    run_instr("beq_taken",   32'h00208463, 1'b1, 1, 1000);
    run_instr("beq_not",     32'h00208463, 1'b0, 1, 1000);
    run_instr("bne_taken",   32'h00209463, 1'b0, 1, 1000);
    run_instr("bne_not",     32'h00209463, 1'b1, 1, 1000);
    run_instr("ebreak",      32'h00100073, 1'b0, 20, 1000);
    run_instr("rst_in_exec", 32'h002081B3, 1'b0, 1, INSTR_LAT + 3);
    run_instr("bad_r_f3",    32'h002091B3, 1'b0, 3, 1000);
    run_instr("bad_ld_f3",   32'h0080A283, 1'b0, 2, 1000);
    run_instr("bad_br_f3",   32'h0020C463, 1'b1, 2, 1000);

    for (int n = 0; n < N_RANDOM; n++) begin
      ir  = $urandom();
      cls = $urandom_range(0, 7);
      case (cls)
        0, 1: begin
          ir[6:0] = 7'b0110011;
          if ($urandom_range(0, 3) != 0) ir[14:12] = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'd7;
        end
        2: begin
          ir[6:0] = 7'b0010011;
          if ($urandom_range(0, 3) != 0) ir[14:12] = 3'd0;
        end
        3, 4: begin
          ir[6:0] = (cls == 3) ? 7'b0000011 : 7'b0100011;
          if ($urandom_range(0, 3) != 0) ir[14:12] = 3'd3;
        end
        5, 6: begin
          ir[6:0] = 7'b1100011;
          if ($urandom_range(0, 3) != 0) ir[14:12] = 3'($urandom_range(0, 1));
        end
        default: ;
      endcase
      hold  = $urandom_range(1, 4);
      trunc = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 8) : 1000;
      run_instr("random", ir, 1'($urandom_range(0, 1)), hold, trunc);
    end

    done = 1'b1;
    repeat (3) @(negedge CLK);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
